// File: rtl/snake_head_if.sv
// Handshake and head-position bundle between the snake head controller and
// the drawing FSM / body shift registers.
//   step_req  : new head valid on head_x/head_y (controller -> downstream)
//   step_ack  : downstream consumed the head (downstream -> controller)
//   head_x    : head cell top-left x, 8 bits
//   head_y    : head cell top-left y, 7 bits
//   dir       : committed direction, 00 right, 01 down, 10 up, 11 left
//   dead      : wall hit, sticky until reset
interface snake_head_if;
    logic       step_req;
    logic       step_ack;
    logic [7:0] head_x;
    logic [6:0] head_y;
    logic [1:0] dir;
    logic       dead;

    modport master (
        output step_req, head_x, head_y, dir, dead,
        input  step_ack
    );

    modport slave (
        input  step_req, head_x, head_y, dir, dead,
        output step_ack
    );
endinterface

// File: rtl/snake_head_ctrl.sv
// Game-tick and head-position controller for the 160x120 snake display.
// Turns the push-buttons into a direction (refusing 180 degree reversals),
// advances the head one cell per game tick, detects wall hits and hands each
// new head to the drawing FSM / body shift registers over step_req/step_ack.
//   CLOCK_50 : system clock
//   Resetn   : synchronous, active-low reset
//   KEY[3:0] : push-buttons, active-low, asynchronous
//              (0 right, 1 down, 2 up, 3 left)
//   go       : run enable, low pauses the game
//   bus      : snake_head_if master (step_req/ack, head_x/y, dir, dead)
//
// state | meaning
// IDLE  | paused, tick counter frozen
// RUN   | counting toward the next game tick
// WAIT  | new head offered, waiting for step_ack
// DEAD  | wall hit, only reset leaves
module snake_head_ctrl #(
    parameter int XDIM    = 10,
    parameter int XSCREEN = 160,
    parameter int YSCREEN = 120,
    parameter int X0      = 80,
    parameter int Y0      = 60,
    parameter int K       = 20
) (
    input  logic                CLOCK_50,
    input  logic                Resetn,
    input  logic [3:0]          KEY,
    input  logic                go,
    snake_head_if.master        bus
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_WAIT, S_DEAD} state_t;

    localparam logic [7:0] X_STEP = 8'(XDIM);
    localparam logic [6:0] Y_STEP = 7'(XDIM);
    localparam logic [7:0] X_MAX  = 8'(XSCREEN - 2 * XDIM);
    localparam logic [6:0] Y_MAX  = 7'(YSCREEN - 2 * XDIM);

    state_t         state_q, state_d;
    logic [K-1:0]   cnt_q, cnt_d;
    logic [3:0]     key_s1_q, key_s1_d;
    logic [3:0]     key_s2_q, key_s2_d;
    logic [3:0]     key_s3_q, key_s3_d;
    logic [7:0]     head_x_q, head_x_d;
    logic [6:0]     head_y_q, head_y_d;
    logic [1:0]     dir_q, dir_d;
    logic [1:0]     pend_dir_q, pend_dir_d;
    logic           step_req_q, step_req_d;
    logic           dead_q, dead_d;

    logic [3:0]     key_fall;
    logic           press_valid;
    logic [1:0]     press_dir;
    logic [7:0]     next_x;
    logic [6:0]     next_y;
    logic           out_of_bounds;
    logic           tick;

    assign tick = &cnt_q;

    always_comb begin
        key_s1_d      = KEY;
        key_s2_d      = key_s1_q;
        key_s3_d      = key_s2_q;
        state_d       = state_q;
        cnt_d         = cnt_q;
        head_x_d      = head_x_q;
        head_y_d      = head_y_q;
        dir_d         = dir_q;
        pend_dir_d    = pend_dir_q;
        step_req_d    = step_req_q;
        dead_d        = dead_q;

        // Buttons are active-low: a press is a 1 -> 0 transition.
        key_fall    = key_s3_q & ~key_s2_q;
        press_valid = |key_fall;
        if (key_fall[0])      press_dir = 2'd0;
        else if (key_fall[1]) press_dir = 2'd1;
        else if (key_fall[2]) press_dir = 2'd2;
        else                  press_dir = 2'd3;

        // Bounds are checked on the current head so the add/subtract below
        // can never wrap into a value that reaches the outputs.
        next_x        = head_x_q;
        next_y        = head_y_q;
        out_of_bounds = 1'b0;
        case (pend_dir_q)
            2'd0: begin
                out_of_bounds = head_x_q > X_MAX;
                next_x        = head_x_q + X_STEP;
            end
            2'd1: begin
                out_of_bounds = head_y_q > Y_MAX;
                next_y        = head_y_q + Y_STEP;
            end
            2'd2: begin
                out_of_bounds = head_y_q < Y_STEP;
                next_y        = head_y_q - Y_STEP;
            end
            default: begin
                out_of_bounds = head_x_q < X_STEP;
                next_x        = head_x_q - X_STEP;
            end
        endcase

        case (state_q)
            S_IDLE: begin
                if (go) state_d = S_RUN;
            end
            S_RUN: begin
                if (!go) begin
                    state_d = S_IDLE;
                end else if (tick) begin
                    cnt_d = '0;
                    if (out_of_bounds) begin
                        state_d = S_DEAD;
                        dead_d  = 1'b1;
                    end else begin
                        head_x_d   = next_x;
                        head_y_d   = next_y;
                        dir_d      = pend_dir_q;
                        step_req_d = 1'b1;
                        state_d    = S_WAIT;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_WAIT: begin
                if (bus.step_ack) begin
                    step_req_d = 1'b0;
                    state_d    = S_RUN;
                end
            end
            S_DEAD: begin
                dead_d     = 1'b1;
                step_req_d = 1'b0;
            end
            default: state_d = S_IDLE;
        endcase

        // Reversal is judged against the committed direction, not pend_dir,
        // so a turn-then-reverse sequence before a tick stays legal.
        if (press_valid && (press_dir != ~dir_q)) pend_dir_d = press_dir;
    end

    always_ff @(posedge CLOCK_50) begin
        if (!Resetn) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            key_s1_q   <= 4'hF;
            key_s2_q   <= 4'hF;
            key_s3_q   <= 4'hF;
            head_x_q   <= 8'(X0);
            head_y_q   <= 7'(Y0);
            dir_q      <= 2'd2;
            pend_dir_q <= 2'd2;
            step_req_q <= 1'b0;
            dead_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            key_s1_q   <= key_s1_d;
            key_s2_q   <= key_s2_d;
            key_s3_q   <= key_s3_d;
            head_x_q   <= head_x_d;
            head_y_q   <= head_y_d;
            dir_q      <= dir_d;
            pend_dir_q <= pend_dir_d;
            step_req_q <= step_req_d;
            dead_q     <= dead_d;
        end
    end

    assign bus.step_req = step_req_q;
    assign bus.head_x   = head_x_q;
    assign bus.head_y   = head_y_q;
    assign bus.dir      = dir_q;
    assign bus.dead     = dead_q;

endmodule
